lcd_avalon_responder: RTL and testbench

- Avalon-MM slave at the far end of the slow-peripheral clock-crossing bridge's master port.
- Accepts word-addressed reads and writes on the master clock domain and runs them as timed HD44780-style character-LCD bus cycles (RS, RW, E, DB[7:0]).
- Returns read data with a variable latency using readdatavalid.
- Holds waitrequest while a bus cycle or the post-write recovery is in progress.

---
 rtl/lcd_avalon_responder.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_avalon_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_avalon_responder.sv
// Avalon-MM slave that runs word-addressed commands as timed HD44780-style LCD bus cycles.
// Build option LCD_BUSY_POLL_EN: poll the LCD busy flag after writes instead of a fixed recovery delay.
module lcd_avalon_responder #(
    parameter int SETUP_CYCLES   = 4,
    parameter int ENABLE_CYCLES  = 12,
    parameter int HOLD_CYCLES    = 4,
    parameter int RECOVER_CYCLES = 2000,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data_out,
    output logic        lcd_data_oe,
    input  logic [7:0]  lcd_data_in,
    output logic        lcd_on,
    output logic [2:0]  fsm_state
);

    // Handshake: a command transfers on a clock edge where (read|write)=1 and waitrequest=0;
    // read data transfers on every edge where readdatavalid=1, one response per accepted read, in order.

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETUP       = 3'd1,
        ENABLE      = 3'd2,
        HOLD        = 3'd3,
        RECOVER     = 3'd4,
        POLL_SETUP  = 3'd5,
        POLL_ENABLE = 3'd6,
        POLL_HOLD   = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENABLE_LOAD  = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_write_q, is_write_d;
    logic             busy_q, busy_d;
    logic             rs_d, rw_d, e_d, oe_d, on_d, rvalid_d;
    logic [7:0]       dout_d;
    logic [31:0]      rdata_d;
    logic             accept;
    logic             cnt_done;
    logic             unused_bits;

    assign waitrequest = (state_q != IDLE);
    assign accept      = (read | write) & ~waitrequest;
    assign cnt_done    = (cnt_q == '0);
    assign fsm_state   = state_q;
    assign unused_bits = ^{writedata[31:8], byteenable[3:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        busy_d     = busy_q;
        rs_d       = lcd_rs;
        rw_d       = lcd_rw;
        dout_d     = lcd_data_out;
        on_d       = lcd_on;
        rdata_d    = readdata;
        rvalid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // read&write together is treated as a write
                    if (write) begin
                        if (!address[1] && byteenable[0]) begin
                            rs_d       = address[0];
                            rw_d       = 1'b0;
                            dout_d     = writedata[7:0];
                            is_write_d = 1'b1;
                            state_d    = SETUP;
                            cnt_d      = SETUP_LOAD;
                        end else if (address == 2'd2 && byteenable[0]) begin
                            on_d = writedata[0];
                        end
                    end else if (!address[1]) begin
                        rs_d       = address[0];
                        rw_d       = 1'b1;
                        is_write_d = 1'b0;
                        state_d    = SETUP;
                        cnt_d      = SETUP_LOAD;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = (address == 2'd2) ? {31'b0, lcd_on} : 32'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    state_d = ENABLE;
                    cnt_d   = ENABLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ENABLE: begin
                if (cnt_done) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    if (!is_write_q) rdata_d = {24'b0, lcd_data_in};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    if (is_write_q) begin
`ifdef LCD_BUSY_POLL_EN
                        state_d = POLL_SETUP;
                        cnt_d   = SETUP_LOAD;
                        rs_d    = 1'b0;
                        rw_d    = 1'b1;
`else
                        state_d = RECOVER;
                        cnt_d   = RECOVER_LOAD;
`endif
                    end else begin
                        state_d  = IDLE;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_done) state_d = IDLE;
                else          cnt_d   = cnt_q - 1'b1;
            end
`ifdef LCD_BUSY_POLL_EN
            POLL_SETUP: begin
                if (cnt_done) begin
                    state_d = POLL_ENABLE;
                    cnt_d   = ENABLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            POLL_ENABLE: begin
                if (cnt_done) begin
                    state_d = POLL_HOLD;
                    cnt_d   = HOLD_LOAD;
                    busy_d  = lcd_data_in[7];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            POLL_HOLD: begin
                if (cnt_done) begin
                    state_d = busy_q ? POLL_SETUP : IDLE;
                    cnt_d   = SETUP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Strobe and bus drive are registered from the next state so they never glitch
        e_d  = (state_d == ENABLE) || (state_d == POLL_ENABLE);
        oe_d = is_write_d && (state_d inside {SETUP, ENABLE, HOLD});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_write_q    <= 1'b0;
            busy_q        <= 1'b0;
            lcd_rs        <= 1'b0;
            lcd_rw        <= 1'b1;
            lcd_e         <= 1'b0;
            lcd_data_out  <= 8'h00;
            lcd_data_oe   <= 1'b0;
            lcd_on        <= 1'b0;
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_write_q    <= is_write_d;
            busy_q        <= busy_d;
            lcd_rs        <= rs_d;
            lcd_rw        <= rw_d;
            lcd_e         <= e_d;
            lcd_data_out  <= dout_d;
            lcd_data_oe   <= oe_d;
            lcd_on        <= on_d;
            readdata      <= rdata_d;
            readdatavalid <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_lcd_avalon_responder.sv
// Self-checking bench for lcd_avalon_responder (default build, fixed recovery delay).
module tb_lcd_avalon_responder;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic [7:0]  lcd_data_out;
    logic        lcd_data_oe;
    logic [7:0]  lcd_data_in;
    logic        lcd_on;
    logic [2:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] exp_data;
    int          exp_cyc;

    lcd_avalon_responder dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_e         (lcd_e),
        .lcd_data_out  (lcd_data_out),
        .lcd_data_oe   (lcd_data_oe),
        .lcd_data_in   (lcd_data_in),
        .lcd_on        (lcd_on),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every readdatavalid pops one expected word and its expected cycle
    always @(negedge clk) begin
        if (!reset && readdatavalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_data = exp_q.pop_front();
                exp_cyc  = cyc_q.pop_front();
                check("rdata", readdata, exp_data);
                check("rvalid_cycle", cyc, exp_cyc);
            end
        end
    end

    // driver tasks
    task automatic avalon_cmd(input logic is_rd, input logic is_wr, input logic [1:0] addr,
                              input logic [31:0] data, input logic [3:0] be, output int acc_cyc);
        int n = 0;
        @(negedge clk);
        address    = addr;
        read       = is_rd;
        write      = is_wr;
        writedata  = data;
        byteenable = be;
        while (waitrequest && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        read    = 1'b0;
        write   = 1'b0;
    endtask

    task automatic avalon_read(input logic [1:0] addr, input logic [31:0] exp, input int latency);
        int acc;
        avalon_cmd(1'b1, 1'b0, addr, 32'h0, 4'hF, acc);
        exp_q.push_back(exp);
        cyc_q.push_back(acc + latency - 1);
    endtask

    task automatic observe(input int n, output int e_cnt, output int wr_cnt, output int e_first);
        e_cnt   = 0;
        wr_cnt  = 0;
        e_first = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (waitrequest) wr_cnt++;
            if (lcd_e) begin
                e_cnt++;
                if (e_first < 0) e_first = i;
            end
        end
    endtask

    int acc, e_cnt, wr_cnt, e_first, bad, oe_after, rv_cnt;
    logic [7:0] rnd_byte;
    logic [1:0] rnd_addr;

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0;
        writedata = 32'h0; byteenable = 4'h0; lcd_data_in = 8'h00;

        // reset values after 5 idle clocks
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_rvalid", {31'b0, readdatavalid}, 32'd0);
        check("rst_waitreq", {31'b0, waitrequest}, 32'd0);
        check("rst_rs", {31'b0, lcd_rs}, 32'd0);
        check("rst_rw", {31'b0, lcd_rw}, 32'd1);
        check("rst_e", {31'b0, lcd_e}, 32'd0);
        check("rst_dout", {24'b0, lcd_data_out}, 32'd0);
        check("rst_oe", {31'b0, lcd_data_oe}, 32'd0);
        check("rst_on", {31'b0, lcd_on}, 32'd0);

        // data write 0x41: 4 setup, 12 enable, 4 hold, 2000 recover
        avalon_cmd(1'b0, 1'b1, 2'd1, 32'h41, 4'hF, acc);
        e_cnt = 0; wr_cnt = 0; e_first = -1; bad = 0; oe_after = 0;
        for (int i = 0; i < 2030; i++) begin
            @(negedge clk);
            if (waitrequest) wr_cnt++;
            if (lcd_e) begin
                e_cnt++;
                if (e_first < 0) e_first = i;
            end
            if (i < 20 && (lcd_rs !== 1'b1 || lcd_rw !== 1'b0 || lcd_data_oe !== 1'b1 ||
                           lcd_data_out !== 8'h41)) bad++;
            if (i >= 20 && lcd_data_oe) oe_after++;
        end
        check("wr_e_first", e_first, 32'd4);
        check("wr_e_len", e_cnt, 32'd12);
        check("wr_waitreq_len", wr_cnt, 32'd2020);
        check("wr_bus_signals", bad, 32'd0);
        check("wr_oe_released", oe_after, 32'd0);

        // instruction read with busy flag set: latency 21
        lcd_data_in = 8'h80;
        avalon_read(2'd0, 32'h0000_0080, 21);
        bad = 0; e_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (lcd_e) e_cnt++;
            if (i < 20 && (lcd_rw !== 1'b1 || lcd_data_oe !== 1'b0 || lcd_rs !== 1'b0)) bad++;
        end
        check("rd0_bus_signals", bad, 32'd0);
        check("rd0_e_len", e_cnt, 32'd12);
        check("rd0_drained", exp_q.size(), 32'd0);

        // random LCD reads
        for (int k = 0; k < 3; k++) begin
            rnd_byte    = 8'($urandom_range(0, 255));
            rnd_addr    = 2'($urandom_range(0, 1));
            lcd_data_in = rnd_byte;
            avalon_read(rnd_addr, {24'b0, rnd_byte}, 21);
            repeat (10) @(negedge clk);
            check("rnd_rs", {31'b0, lcd_rs}, {31'b0, rnd_addr[0]});
            repeat (15) @(negedge clk);
        end
        check("rnd_drained", exp_q.size(), 32'd0);

        // CSR write then read: zero wait states, no bus activity
        avalon_cmd(1'b0, 1'b1, 2'd2, 32'h1, 4'h1, acc);
        @(negedge clk);
        check("csr_on_set", {31'b0, lcd_on}, 32'd1);
        avalon_read(2'd2, 32'h1, 1);
        observe(5, e_cnt, wr_cnt, e_first);
        check("csr_no_e", e_cnt, 32'd0);
        check("csr_no_wait", wr_cnt, 32'd0);
        avalon_cmd(1'b0, 1'b1, 2'd2, 32'h0, 4'h0, acc);
        @(negedge clk);
        check("csr_be0_ignored", {31'b0, lcd_on}, 32'd1);

        // disabled byte lane and reserved address
        avalon_cmd(1'b0, 1'b1, 2'd0, 32'h55, 4'b1110, acc);
        observe(10, e_cnt, wr_cnt, e_first);
        check("be_off_no_e", e_cnt, 32'd0);
        check("be_off_no_wait", wr_cnt, 32'd0);
        avalon_read(2'd3, 32'h0, 1);
        avalon_cmd(1'b0, 1'b1, 2'd3, 32'h0, 4'hF, acc);
        repeat (3) @(negedge clk);
        check("addr3_wr_ignored", {31'b0, lcd_on}, 32'd1);
        check("addr3_drained", exp_q.size(), 32'd0);

        // read and write together act as a write: no response
        avalon_cmd(1'b1, 1'b1, 2'd2, 32'h0, 4'h1, acc);
        repeat (5) @(negedge clk);
        check("rw_both_is_write", {31'b0, lcd_on}, 32'd0);

        // reset in the middle of an LCD read's enable phase
        lcd_data_in = 8'h3C;
        avalon_cmd(1'b1, 1'b0, 2'd1, 32'h0, 4'hF, acc);
        repeat (8) @(negedge clk);
        check("pre_rst_e", {31'b0, lcd_e}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_e", {31'b0, lcd_e}, 32'd0);
        check("async_rst_oe", {31'b0, lcd_data_oe}, 32'd0);
        check("async_rst_wait", {31'b0, waitrequest}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (readdatavalid) rv_cnt++;
        end
        check("rst_no_rvalid", rv_cnt, 32'd0);

        lcd_data_in = 8'hA7;
        avalon_read(2'd1, 32'h0000_00A7, 21);
        repeat (25) @(negedge clk);
        check("post_rst_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
